id_fsm_core: RTL and testbench

Streaming identifier recogniser. Consumes one 8-bit ASCII character per clock and asserts `out` while the characters received since the last delimiter form a legal identifier: a letter followed by zero or more letters or digits. It sits behind a character source in the lexer front end and flags identifier tokens to downstream token logic.

---
 rtl/id_fsm_core_if.sv | 9 +
 rtl/id_fsm_core.sv | 68 ++++++
 tb/tb_id_fsm_core.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/id_fsm_core_if.sv
// Character stream into the identifier recogniser and the identifier flag back out.
// char_code carries the spec's `char` (a reserved word in SystemVerilog).
interface id_fsm_core_if;
    logic [7:0] char_code;
    logic       out;

    modport master (output char_code, input out);
    modport slave  (input char_code, output out);
endinterface

// File: rtl/id_fsm_core.sv
// Streaming identifier recogniser: out=1 while the token since the last delimiter is letter{letter|digit}.
// Optional macro ID_UNDERSCORE_EN: when defined, '_' (0x5F) is treated as a letter.

// state    | meaning
// S_START  | no token in progress, out=0
// S_LETTER | valid identifier, last char a letter, out=1
// S_DIGIT  | valid identifier, last char a digit, out=1
// S_ERR    | token started with a digit, out=0 until next delimiter
module id_fsm_core (
    input  logic           clk,
    input  logic           rst_n,
    id_fsm_core_if.slave   bus
);
    typedef enum logic [1:0] {
        S_START  = 2'b00,
        S_LETTER = 2'b01,
        S_DIGIT  = 2'b10,
        S_ERR    = 2'b11
    } state_t;

    state_t state;
    state_t nxt;
    logic   is_letter;
    logic   is_digit;

    always_comb begin
        is_letter = ((bus.char_code >= 8'h41) && (bus.char_code <= 8'h5A)) ||
                    ((bus.char_code >= 8'h61) && (bus.char_code <= 8'h7A));
`ifdef ID_UNDERSCORE_EN
        if (bus.char_code == 8'h5F) is_letter = 1'b1;
`else
        is_letter = is_letter;
`endif
        is_digit  = (bus.char_code >= 8'h30) && (bus.char_code <= 8'h39);
    end

    always_comb begin
        nxt = S_START;
        case (state)
            S_START: begin
                if (is_letter)     nxt = S_LETTER;
                else if (is_digit) nxt = S_ERR;
                else               nxt = S_START;
            end
            S_LETTER, S_DIGIT: begin
                if (is_letter)     nxt = S_LETTER;
                else if (is_digit) nxt = S_DIGIT;
                else               nxt = S_START;
            end
            S_ERR: begin
                if (is_letter || is_digit) nxt = S_ERR;
                else                       nxt = S_START;
            end
            default: nxt = S_START;
        endcase
    end

    // out is registered alongside the state so it never depends combinationally on char_code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_START;
            bus.out <= 1'b0;
        end else begin
            state   <= nxt;
            bus.out <= (nxt == S_LETTER) || (nxt == S_DIGIT);
        end
    end
endmodule

// File: tb/tb_id_fsm_core.sv
// Self-checking bench for id_fsm_core: directed vector table, reset sequences, random stream vs token model.
// Honours ID_UNDERSCORE_EN to match the build of the design.
module tb_id_fsm_core;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    byte unsigned tok[$];

    id_fsm_core_if bus ();

    id_fsm_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c;
        logic       exp;
    } vec_t;

    vec_t tbl[$];

    function automatic bit m_letter(input byte unsigned c);
        bit r;
        r = (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
`ifdef ID_UNDERSCORE_EN
        if (c == 8'h5F) r = 1'b1;
`endif
        return r;
    endfunction

    function automatic bit m_digit(input byte unsigned c);
        return (c >= 8'h30 && c <= 8'h39);
    endfunction

    // The token model: a token is the list of characters since the last delimiter.
    function automatic bit model_out();
        return (tok.size() > 0) && m_letter(tok[0]);
    endfunction

    task automatic model_push(input byte unsigned c);
        if (m_letter(c) || m_digit(c)) tok.push_back(c);
        else tok.delete();
    endtask

    task automatic check(input string name, input logic exp);
        vectors++;
        if (bus.out !== exp) begin
            miscompares++;
            $display("FAIL %s: out=%b expected %b at %0t", name, bus.out, exp, $time);
        end
    endtask

    task automatic apply(input byte unsigned c, input string name);
        bus.char_code = c;
        @(posedge clk);
        #1;
        model_push(c);
        check(name, model_out());
    endtask

    task automatic add(input logic [7:0] c, input logic exp);
        vec_t v;
        v.c = c;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.char_code = 8'h61;
        #1;
        check("reset_async", 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.char_code = (i % 2 == 0) ? 8'h62 : 8'h61;
            check("reset_hold", 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tok.delete();
        apply(8'h61, "post_reset_a");
        apply(8'h20, "post_reset_delim");

        // basic identifier then '/'
        add(8'h61, 1); add(8'h62, 1); add(8'h63, 1); add(8'h64, 1);
        add(8'h31, 1); add(8'h32, 1); add(8'h33, 1); add(8'h34, 1);
        add(8'h2F, 0);
        // leading digit, then space, then x
        add(8'h31, 0); add(8'h61, 0); add(8'h62, 0); add(8'h20, 0); add(8'h78, 1);
        add(8'h20, 0);
        // class boundaries that terminate
        add(8'h61, 1); add(8'h40, 0);
        add(8'h61, 1); add(8'h5B, 0);
        add(8'h61, 1); add(8'h60, 0);
        add(8'h61, 1); add(8'h7B, 0);
        add(8'h61, 1); add(8'h2F, 0);
        add(8'h61, 1); add(8'h3A, 0);
        add(8'h61, 1); add(8'hC1, 0);
        add(8'h61, 1); add(8'h00, 0);
        add(8'h61, 1); add(8'hFF, 0);
        // class boundaries that continue
        add(8'h61, 1); add(8'h41, 1); add(8'h5A, 1); add(8'h7A, 1);
        add(8'h30, 1); add(8'h39, 1); add(8'h20, 0);
        // repeated delimiter, repeated digit in error token
        add(8'h20, 0); add(8'h20, 0); add(8'h39, 0); add(8'h39, 0); add(8'h7A, 0);
        add(8'h2C, 0);
        // underscore handling
`ifdef ID_UNDERSCORE_EN
        add(8'h5F, 1); add(8'h61, 1); add(8'h31, 1); add(8'h20, 0);
        add(8'h61, 1); add(8'h5F, 1); add(8'h20, 0);
`else
        add(8'h5F, 0); add(8'h61, 1); add(8'h20, 0);
        add(8'h61, 1); add(8'h5F, 0); add(8'h61, 1); add(8'h20, 0);
`endif

        foreach (tbl[i]) begin
            bus.char_code = tbl[i].c;
            @(posedge clk);
            #1;
            model_push(tbl[i].c);
            check($sformatf("table[%0d] char=%02h", i, tbl[i].c), tbl[i].exp);
        end

        // reset mid-token discards it; the following '3' starts an invalid token
        apply(8'h61, "mid_a");
        apply(8'h62, "mid_b");
        apply(8'h31, "mid_1");
        bus.char_code = 8'h32;
        #2;
        rst_n = 1'b0;
        #1;
        tok.delete();
        check("mid_reset_immediate", 1'b0);
        @(posedge clk);
        #2;
        check("mid_reset_held", 1'b0);
        rst_n = 1'b1;
        apply(8'h33, "after_reset_digit");
        apply(8'h61, "after_reset_err_letter");
        apply(8'h20, "after_reset_delim");

        // random stream against the token model
        for (int i = 0; i < 3000; i++) begin
            byte unsigned c;
            case ($urandom_range(0, 5))
                0, 1:    c = byte'($urandom_range(8'h61, 8'h7A));
                2:       c = byte'($urandom_range(8'h41, 8'h5A));
                3:       c = byte'($urandom_range(8'h30, 8'h39));
                4:       c = ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h5F;
                default: c = byte'($urandom_range(0, 255));
            endcase
            apply(c, $sformatf("random[%0d] char=%02h", i, c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
